// File: rtl/adder_pkg.sv
// Shared types and default sizing for the wide-add sequencer and its 16-bit slice adder.
// No latency or flow control of its own.
package adder_pkg;

    localparam int DEF_WORD_W    = 16;
    localparam int DEF_NUM_WORDS = 4;
    localparam int DEF_ADD_LAT   = 1;
    localparam int DEF_TOTAL_W   = DEF_WORD_W * DEF_NUM_WORDS;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/prefix_adder16.sv
// 16-bit Kogge-Stone adder with registered Sum/Cout; 1-cycle latency.
// No flow control: a new operand set is accepted every cycle.
module prefix_adder16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4;
    logic [15:0] carry;

    // Prefix levels shift ones into the propagate vector so low bits keep their partial groups.
    always_comb begin
        g0 = a_i & b_i;
        p0 = a_i ^ b_i;
        g1 = g0 | (p0 & {g0[14:0], 1'b0});
        p1 = p0 & {p0[14:0], 1'b1};
        g2 = g1 | (p1 & {g1[13:0], 2'b0});
        p2 = p1 & {p1[13:0], 2'b11};
        g3 = g2 | (p2 & {g2[11:0], 4'b0});
        p3 = p2 & {p2[11:0], 4'hF};
        g4 = g3 | (p3 & {g3[7:0], 8'b0});
        p4 = p3 & {p3[7:0], 8'hFF};
        carry = g4 | (p4 & {16{cin_i}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else begin
            sum_o  <= p0 ^ {carry[14:0], cin_i};
            cout_o <= carry[15];
        end
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Serialises a wide add through a WORD_W-bit slice adder, LSW first, carry chained between slices.
// Latency NUM_WORDS*(1+ADD_LAT) edges; one op in flight, result held until out_ready.
module wide_add_sequencer
    import adder_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADD_LAT   = DEF_ADD_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in_a,
    input  logic [WORD_W*NUM_WORDS-1:0] in_b,
    input  logic                        in_cin,
    output logic [WORD_W-1:0]           add_a,
    output logic [WORD_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [WORD_W-1:0]           add_sum,
    input  logic                        add_cout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] out_sum,
    output logic                        out_cout,
    output logic                        busy
);

    localparam int TOT_W = WORD_W * NUM_WORDS;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = 3;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [TOT_W-1:0]   a_q, a_d, b_q, b_d;
    logic [TOT_W-1:0]   sum_q, sum_d;
    logic [WORD_W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;

    assign idx_nxt = idx_q + 1'b1;

    // The adder operands are loaded on the edge that enters ISSUE so the adder sees them for the whole ISSUE cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d       = in_a;
                    b_d       = in_b;
                    carry_d   = in_cin;
                    idx_d     = '0;
                    add_a_d   = in_a[WORD_W-1:0];
                    add_b_d   = in_b[WORD_W-1:0];
                    add_cin_d = in_cin;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(ADD_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    sum_d[idx_q*WORD_W +: WORD_W] = add_sum;
                    carry_d = add_cout;
                    cnt_d   = '0;
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_nxt;
                        add_a_d   = a_q[idx_nxt*WORD_W +: WORD_W];
                        add_b_d   = b_q[idx_nxt*WORD_W +: WORD_W];
                        add_cin_d = add_cout;
                        state_d   = S_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;

endmodule
